// File: rtl/canvas_plotter.sv
// Turns mouse-pad draw/erase requests into single-pixel framebuffer writes.
// Optional STAMP_DEDUP_EN suppresses restamping an identical brush at an unchanged cursor.
//
// state | meaning
// IDLE  | waiting for an erase rising edge or a draw request
// STAMP | emitting BRUSH*BRUSH brush pixels, dx fastest
// CLEAR | raster sweep of the whole canvas in CLEAR_COLOR
module canvas_plotter #(
  parameter int          WIDTH       = 160,
  parameter int          HEIGHT      = 120,
  parameter int          X_W         = 8,
  parameter int          Y_W         = 7,
  parameter int          BRUSH       = 2,
  parameter logic [14:0] CLEAR_COLOR = 15'h7FFF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           draw,
  input  logic           erase,
  input  logic [14:0]    color,
  input  logic [X_W-1:0] cursor_x,
  input  logic [Y_W-1:0] cursor_y,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [14:0]    vga_color,
  output logic           vga_plot,
  output logic           busy,
  output logic           clear_done
);

  typedef enum logic [1:0] {IDLE, STAMP, CLEAR} state_t;

  localparam logic [X_W:0]   W_LIM    = (X_W+1)'(WIDTH);
  localparam logic [Y_W:0]   H_LIM    = (Y_W+1)'(HEIGHT);
  localparam logic [X_W-1:0] X_LAST   = X_W'(WIDTH-1);
  localparam logic [Y_W-1:0] Y_LAST   = Y_W'(HEIGHT-1);
  localparam logic [1:0]     D_LAST   = 2'(BRUSH-1);
  localparam logic           ONE_PIX  = (WIDTH == 1) && (HEIGHT == 1);

  state_t         state_q;
  logic           erase_q;
  logic [X_W-1:0] x0_q, sx_q, vga_x_q;
  logic [Y_W-1:0] y0_q, sy_q, vga_y_q;
  logic [1:0]     dx_q, dy_q;
  logic [14:0]    vga_color_q;
  logic           vga_plot_q, busy_q, done_q;

  logic           erase_rise, stamp_last, sweep_last, dup;
  logic [1:0]     dx_d, dy_d;
  logic [X_W:0]   sum_x;
  logic [Y_W:0]   sum_y;
  logic [X_W-1:0] sx_d;
  logic [Y_W-1:0] sy_d;

  assign erase_rise = erase && !erase_q;
  assign stamp_last = (dx_q == D_LAST) && (dy_q == D_LAST);
  assign dx_d       = (dx_q == D_LAST) ? 2'd0 : dx_q + 2'd1;
  assign dy_d       = (dx_q == D_LAST) ? dy_q + 2'd1 : dy_q;
  // One bit wider than the coordinate so off-canvas pixels are detected, never wrapped
  assign sum_x      = {1'b0, x0_q} + {{(X_W-1){1'b0}}, dx_d};
  assign sum_y      = {1'b0, y0_q} + {{(Y_W-1){1'b0}}, dy_d};
  assign sweep_last = (sx_q == X_LAST) && (sy_q == Y_LAST);
  assign sx_d       = (sx_q == X_LAST) ? '0 : sx_q + X_W'(1);
  assign sy_d       = (sx_q == X_LAST) ? sy_q + Y_W'(1) : sy_q;

`ifdef STAMP_DEDUP_EN
  logic           last_vld_q;
  logic [X_W-1:0] last_x_q;
  logic [Y_W-1:0] last_y_q;
  logic [14:0]    last_c_q;
  assign dup = last_vld_q && (last_x_q == cursor_x) && (last_y_q == cursor_y) &&
               (last_c_q == color);
`else
  assign dup = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      erase_q     <= 1'b0;
      x0_q        <= '0;
      y0_q        <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      sx_q        <= '0;
      sy_q        <= '0;
      vga_x_q     <= '0;
      vga_y_q     <= '0;
      vga_color_q <= '0;
      vga_plot_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef STAMP_DEDUP_EN
      last_vld_q  <= 1'b0;
      last_x_q    <= '0;
      last_y_q    <= '0;
      last_c_q    <= '0;
`endif
    end else begin
      erase_q    <= erase;
      vga_plot_q <= 1'b0;
      done_q     <= 1'b0;
      // Erase wins over draw and aborts a stamp in progress
      if (erase_rise && state_q != CLEAR) begin
        state_q     <= CLEAR;
        busy_q      <= 1'b1;
        sx_q        <= '0;
        sy_q        <= '0;
        vga_x_q     <= '0;
        vga_y_q     <= '0;
        vga_color_q <= CLEAR_COLOR;
        vga_plot_q  <= 1'b1;
        done_q      <= ONE_PIX;
`ifdef STAMP_DEDUP_EN
        last_vld_q  <= 1'b0;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            if (draw && !dup) begin
              state_q     <= STAMP;
              busy_q      <= 1'b1;
              x0_q        <= cursor_x;
              y0_q        <= cursor_y;
              dx_q        <= '0;
              dy_q        <= '0;
              vga_x_q     <= cursor_x;
              vga_y_q     <= cursor_y;
              vga_color_q <= color;
              vga_plot_q  <= ({1'b0, cursor_x} < W_LIM) && ({1'b0, cursor_y} < H_LIM);
            end else begin
              busy_q <= 1'b0;
            end
          end
          STAMP: begin
            if (stamp_last) begin
              state_q    <= IDLE;
              busy_q     <= 1'b0;
`ifdef STAMP_DEDUP_EN
              last_vld_q <= 1'b1;
              last_x_q   <= x0_q;
              last_y_q   <= y0_q;
              last_c_q   <= vga_color_q;
`endif
            end else begin
              dx_q       <= dx_d;
              dy_q       <= dy_d;
              vga_x_q    <= sum_x[X_W-1:0];
              vga_y_q    <= sum_y[Y_W-1:0];
              vga_plot_q <= (sum_x < W_LIM) && (sum_y < H_LIM);
            end
          end
          CLEAR: begin
            if (sweep_last) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              sx_q       <= sx_d;
              sy_q       <= sy_d;
              vga_x_q    <= sx_d;
              vga_y_q    <= sy_d;
              vga_plot_q <= 1'b1;
              done_q     <= (sx_d == X_LAST) && (sy_d == Y_LAST);
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_color  = vga_color_q;
  assign vga_plot   = vga_plot_q;
  assign busy       = busy_q;
  assign clear_done = done_q;

endmodule

// File: tb/tb_canvas_plotter.sv
// Scoreboard bench: a full-size plotter for stamps and a 4x3 plotter for sweeps.
module tb_canvas_plotter;

  typedef struct {
    logic [7:0]  x;
    logic [6:0]  y;
    logic [14:0] c;
    logic        done;
    int          cyc;
  } pix_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_draw, a_erase, a_plot, a_busy, a_done;
  logic [14:0] a_color, a_vc;
  logic [7:0]  a_cx, a_vx;
  logic [6:0]  a_cy, a_vy;
  logic        b_draw, b_erase, b_plot, b_busy, b_done;
  logic [14:0] b_color, b_vc;
  logic [7:0]  b_cx, b_vx;
  logic [6:0]  b_cy, b_vy;

  canvas_plotter dut_a (
    .clk(clk), .reset(reset), .draw(a_draw), .erase(a_erase), .color(a_color),
    .cursor_x(a_cx), .cursor_y(a_cy), .vga_x(a_vx), .vga_y(a_vy),
    .vga_color(a_vc), .vga_plot(a_plot), .busy(a_busy), .clear_done(a_done));

  canvas_plotter #(.WIDTH(4), .HEIGHT(3)) dut_b (
    .clk(clk), .reset(reset), .draw(b_draw), .erase(b_erase), .color(b_color),
    .cursor_x(b_cx), .cursor_y(b_cy), .vga_x(b_vx), .vga_y(b_vy),
    .vga_color(b_vc), .vga_plot(b_plot), .busy(b_busy), .clear_done(b_done));

  pix_t qa[$];
  pix_t qb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always @(negedge clk) begin
    pix_t e;
    if (a_plot) begin
      n_chk++;
      if (qa.size() == 0) begin
        n_fail++;
        $display("FAIL a_extra_pixel: got (%0d,%0d) col %h at cycle %0d, required no plot",
                 a_vx, a_vy, a_vc, cyc);
      end else begin
        e = qa.pop_front();
        if (a_vx !== e.x || a_vy !== e.y || a_vc !== e.c || a_done !== e.done || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL a_pixel: got (%0d,%0d) col %h done %b cyc %0d, required (%0d,%0d) col %h done %b cyc %0d",
                   a_vx, a_vy, a_vc, a_done, cyc, e.x, e.y, e.c, e.done, e.cyc);
        end
      end
    end else if (a_done) begin
      n_fail++;
      $display("FAIL a_done_no_plot: got clear_done=1 at cycle %0d, required 0", cyc);
    end
    if (b_plot) begin
      n_chk++;
      if (qb.size() == 0) begin
        n_fail++;
        $display("FAIL b_extra_pixel: got (%0d,%0d) col %h at cycle %0d, required no plot",
                 b_vx, b_vy, b_vc, cyc);
      end else begin
        e = qb.pop_front();
        if (b_vx !== e.x || b_vy !== e.y || b_vc !== e.c || b_done !== e.done || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL b_pixel: got (%0d,%0d) col %h done %b cyc %0d, required (%0d,%0d) col %h done %b cyc %0d",
                   b_vx, b_vy, b_vc, b_done, cyc, e.x, e.y, e.c, e.done, e.cyc);
        end
      end
    end else if (b_done) begin
      n_fail++;
      $display("FAIL b_done_no_plot: got clear_done=1 at cycle %0d, required 0", cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic push_a(input int x, input int y, input logic [14:0] c, input int cy);
    pix_t p;
    p.x = 8'(x); p.y = 7'(y); p.c = c; p.done = 1'b0; p.cyc = cy;
    qa.push_back(p);
  endtask

  // 4x3 raster sweep: (0,0)..(3,2), clear_done only with the last pixel
  task automatic sweep_b(input int base);
    pix_t p;
    for (int i = 0; i < 12; i++) begin
      p.x = 8'(i % 4); p.y = 7'(i / 4); p.c = 15'h7FFF; p.done = (i == 11); p.cyc = base + i;
      qb.push_back(p);
    end
  endtask

  task automatic busy_window_a(input string name);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk(name, a_busy, (i <= 4) ? 32'd1 : 32'd0);
    end
    tick();
  endtask

  initial begin
    int c;
    reset = 1'b1;
    a_draw = 0; a_erase = 0; a_color = '0; a_cx = '0; a_cy = '0;
    b_draw = 0; b_erase = 0; b_color = '0; b_cx = '0; b_cy = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_plot", a_plot, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_xy", {a_vx, a_vy}, 0);
    chk("rst_color", a_vc, 0);
    chk("rst_b_busy", b_busy, 0);
    tick();
    reset = 1'b0;
    repeat (2) tick();

    // basic 2x2 stamp
    c = cyc;
    a_draw = 1; a_cx = 10; a_cy = 20; a_color = 15'h001F;
    push_a(10, 20, 15'h001F, c+1); push_a(11, 20, 15'h001F, c+2);
    push_a(10, 21, 15'h001F, c+3); push_a(11, 21, 15'h001F, c+4);
    tick();
    a_draw = 0;
    busy_window_a("stamp_busy");

    // bottom-right corner: three brush pixels fall off the canvas
    c = cyc;
    a_draw = 1; a_cx = 159; a_cy = 119; a_color = 15'h7C00;
    push_a(159, 119, 15'h7C00, c+1);
    tick();
    a_draw = 0;
    busy_window_a("corner_busy");

    // draw held at a fixed cursor, then the cursor moves
    c = cyc;
    a_draw = 1; a_cx = 5; a_cy = 5; a_color = 15'h0ABC;
    push_a(5, 5, 15'h0ABC, c+1); push_a(6, 5, 15'h0ABC, c+2);
    push_a(5, 6, 15'h0ABC, c+3); push_a(6, 6, 15'h0ABC, c+4);
`ifndef STAMP_DEDUP_EN
    push_a(5, 5, 15'h0ABC, c+6); push_a(6, 5, 15'h0ABC, c+7);
    push_a(5, 6, 15'h0ABC, c+8); push_a(6, 6, 15'h0ABC, c+9);
`endif
    repeat (10) tick();
    a_cx = 6;
    push_a(6, 5, 15'h0ABC, c+11); push_a(7, 5, 15'h0ABC, c+12);
    push_a(6, 6, 15'h0ABC, c+13); push_a(7, 6, 15'h0ABC, c+14);
    tick();
    a_draw = 0;
    repeat (5) tick();

    // reset in the middle of a stamp
    c = cyc;
    a_draw = 1; a_cx = 50; a_cy = 50; a_color = 15'h1111;
    push_a(50, 50, 15'h1111, c+1); push_a(51, 50, 15'h1111, c+2);
    tick();
    a_draw = 0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_plot", a_plot, 0);
    chk("midreset_busy", a_busy, 0);
    chk("midreset_xy", {a_vx, a_vy}, 0);
    tick();
    tick();

    // erase beats draw, draw ignored during the sweep
    c = cyc;
    b_erase = 1; b_draw = 1; b_cx = 1; b_cy = 1; b_color = 15'h0123;
    sweep_b(c+1);
    tick();
    b_erase = 0;
    repeat (11) tick();
    b_draw = 0;
    @(negedge clk);
    chk("sweep_busy_last", b_busy, 1);
    tick();
    @(negedge clk);
    chk("sweep_end_busy", b_busy, 0);
    chk("sweep_end_plot", b_plot, 0);
    tick();

    // erase held for 30 cycles: one sweep; a fresh edge starts the next at once
    c = cyc;
    b_erase = 1;
    sweep_b(c+1);
    repeat (30) tick();
    b_erase = 0;
    tick();
    b_erase = 1;
    sweep_b(c+32);
    tick();
    b_erase = 0;
    repeat (14) tick();

    // erase on the 2nd stamp cycle aborts the stamp
    c = cyc;
    b_draw = 1; b_cx = 1; b_cy = 1; b_color = 15'h1234;
    begin
      pix_t p;
      p.x = 1; p.y = 1; p.c = 15'h1234; p.done = 0; p.cyc = c+1; qb.push_back(p);
      p.x = 2; p.cyc = c+2; qb.push_back(p);
    end
    tick();
    b_draw = 0;
    tick();
    b_erase = 1;
    sweep_b(c+3);
    tick();
    b_erase = 0;
    repeat (14) tick();

    for (int i = 0; i < 50 && (qa.size() != 0 || qb.size() != 0); i++) tick();
    chk("queue_a_drained", qa.size(), 0);
    chk("queue_b_drained", qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
